// File: rtl/div_seq_ctrl.sv
// Iterative radix-2 divider for RV32M DIV/DIVU/REM/REMU with EX-stage handshake,
// fast paths for divide-by-zero / signed overflow, and a last-result operand cache.
module div_seq_ctrl #(
  parameter int unsigned CACHE_EN     = 1,
  parameter int unsigned ITER_PER_CYC = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        en,
  input  logic        sign,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        ready,
  output logic        busy
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 6;
  localparam logic [CW-1:0] ITER_LOAD = CW'(W / ITER_PER_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_CALC = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [W:0]      r_rem;
  logic [W-1:0]    r_dq;
  logic [W-1:0]    r_div;
  logic            r_q_neg;
  logic            r_r_neg;
  logic [W-1:0]    r_quotient;
  logic [W-1:0]    r_remainder;
  logic            r_cache_valid;
  logic [W-1:0]    r_key_a;
  logic [W-1:0]    r_key_b;
  logic            r_key_sign;
  logic [W-1:0]    r_pend_a;
  logic [W-1:0]    r_pend_b;
  logic            r_pend_sign;

  logic            w_hit;
  logic            w_abort;
  logic            w_div_zero;
  logic            w_ovf;
  logic [W-1:0]    w_abs_a;
  logic [W-1:0]    w_abs_b;
  logic [W:0]      w_rem;
  logic [W:0]      w_trial;
  logic [W-1:0]    w_dq;
  logic [W-1:0]    w_q_fix;
  logic [W-1:0]    w_r_fix;

  assign w_hit = (CACHE_EN != 0) && r_cache_valid && (r_state == S_IDLE) &&
                 (op_a == r_key_a) && (op_b == r_key_b) && (sign == r_key_sign);

  // Dropping en mid-operation is an abort just like an EX flush.
  assign w_abort    = flush | ~en;
  assign w_div_zero = (op_b == '0);
  assign w_ovf      = sign && (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
  assign w_abs_a    = (sign && op_a[W-1]) ? W'(-op_a) : op_a;
  assign w_abs_b    = (sign && op_b[W-1]) ? W'(-op_b) : op_b;

  assign ready     = ((r_state == S_IDLE) && (!en || w_hit)) || (r_state == S_DONE);
  assign busy      = (r_state == S_PREP) || (r_state == S_CALC) || (r_state == S_FIX);
  assign quotient  = r_quotient;
  assign remainder = r_remainder;

  // Restoring shift-subtract: dividend bits shift out of r_dq's MSB, quotient bits in at LSB.
  always_comb begin
    w_rem   = r_rem;
    w_dq    = r_dq;
    w_trial = '0;
    for (int i = 0; i < int'(ITER_PER_CYC); i++) begin
      w_trial = {w_rem[W-1:0], w_dq[W-1]};
      w_dq    = {w_dq[W-2:0], 1'b0};
      if (w_trial >= {1'b0, r_div}) begin
        w_rem   = w_trial - {1'b0, r_div};
        w_dq[0] = 1'b1;
      end else begin
        w_rem   = w_trial;
      end
    end
  end

  assign w_q_fix = r_q_neg ? W'(-r_dq) : r_dq;
  assign w_r_fix = r_r_neg ? W'(-r_rem[W-1:0]) : r_rem[W-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_rem         <= '0;
      r_dq          <= '0;
      r_div         <= '0;
      r_q_neg       <= 1'b0;
      r_r_neg       <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_cache_valid <= 1'b0;
      r_key_a       <= '0;
      r_key_b       <= '0;
      r_key_sign    <= 1'b0;
      r_pend_a      <= '0;
      r_pend_b      <= '0;
      r_pend_sign   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (en && !w_hit && !flush) r_state <= S_PREP;
        end
        S_PREP: begin
          if (w_abort) begin
            r_state <= S_IDLE;
          end else begin
            r_pend_a    <= op_a;
            r_pend_b    <= op_b;
            r_pend_sign <= sign;
            r_q_neg     <= sign & (op_a[W-1] ^ op_b[W-1]);
            r_r_neg     <= sign & op_a[W-1];
            r_dq        <= w_abs_a;
            r_div       <= w_abs_b;
            r_rem       <= '0;
            r_cnt       <= ITER_LOAD;
            if (w_div_zero) begin
              r_quotient  <= '1;
              r_remainder <= op_a;
              r_state     <= S_DONE;
            end else if (w_ovf) begin
              r_quotient  <= 32'h8000_0000;
              r_remainder <= '0;
              r_state     <= S_DONE;
            end else begin
              r_state     <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (w_abort) begin
            r_state <= S_IDLE;
          end else begin
            r_rem <= w_rem;
            r_dq  <= w_dq;
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == '0) r_state <= S_FIX;
          end
        end
        S_FIX: begin
          if (w_abort) begin
            r_state <= S_IDLE;
          end else begin
            r_quotient  <= w_q_fix;
            r_remainder <= w_r_fix;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          // Key is committed only once the matching result is in the output regs.
          r_cache_valid <= 1'b1;
          r_key_a       <= r_pend_a;
          r_key_b       <= r_pend_b;
          r_key_sign    <= r_pend_sign;
          r_state       <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
